// File: rtl/square_cell_gen.sv
// rtl/square_cell_gen.sv - per-square move-generation cell for the systolic board array
module square_cell_gen #(
    parameter int COORD_W = 3,
    parameter int MSG_W   = 2*COORD_W + 3,
    parameter int MOVE_W  = 6 + 4*COORD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   xpos,
    input  logic [COORD_W-1:0]   ypos,
    input  logic [3:0]           cpiece,
    input  logic                 side,
    input  logic                 ep_valid,
    input  logic [COORD_W-1:0]   ep_x,
    input  logic [COORD_W-1:0]   ep_y,
    input  logic                 start,
    input  logic                 step,
    input  logic                 kstep,
    input  logic [8*MSG_W-1:0]   nbr_in,
    output logic [8*MSG_W-1:0]   nbr_out,
    input  logic [8*MSG_W-1:0]   kn_in,
    output logic [8*MSG_W-1:0]   kn_out,
    output logic                 mv_valid,
    input  logic                 mv_ready,
    output logic [MOVE_W-1:0]    mv_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [2:0] T_EMPTY  = 3'd0;
    localparam logic [2:0] T_PAWN   = 3'd1;
    localparam logic [2:0] T_KNIGHT = 3'd2;
    localparam logic [2:0] T_BISHOP = 3'd3;
    localparam logic [2:0] T_ROOK   = 3'd4;
    localparam logic [2:0] T_QUEEN  = 3'd5;
    localparam logic [2:0] T_KING   = 3'd6;

    localparam logic [COORD_W-1:0] WHITE_START = COORD_W'(1);
    localparam logic [COORD_W-1:0] BLACK_START = COORD_W'((2**COORD_W) - 2);

    typedef enum logic [1:0] {S_IDLE, S_PROP, S_KDRN, S_DONE} state_t;

    state_t                    state;
    logic                      side_r;
    logic [7:0]                pend;
    logic [7:0][MOVE_W-1:0]    recs;

    logic                      cell_empty, cell_enemy, ep_hit, hit, diag_src;
    logic [2:0]                push_src, dd, t;
    logic [COORD_W-1:0]        start_rank, last_rank, ox, oy, dy;
    logic [MSG_W-1:0]          m, km;
    logic [5:0]                fl;
    logic [7:0]                step_pend, kn_pend, low_bit;
    logic [7:0][MOVE_W-1:0]    step_rec, kn_rec;
    logic [8*MSG_W-1:0]        step_out;

    // Evaluate one propagation round (rays) and one knight round from the current inputs.
    always_comb begin
        cell_empty = (cpiece[2:0] == T_EMPTY);
        cell_enemy = !cell_empty && (cpiece[3] != side_r);
        ep_hit     = ep_valid && (ep_x == xpos) && (ep_y == ypos);
        push_src   = side_r ? 3'd2 : 3'd6;
        start_rank = side_r ? BLACK_START : WHITE_START;
        last_rank  = side_r ? '0 : '1;
        step_pend  = '0;
        step_rec   = '0;
        step_out   = '0;
        kn_pend    = '0;
        kn_rec     = '0;
        m = '0; km = '0; t = T_EMPTY; ox = '0; oy = '0; dy = '0;
        dd = '0; fl = '0; hit = 1'b0; diag_src = 1'b0;
        for (int d = 0; d < 8; d++) begin
            dd = 3'(d);
            m  = nbr_in[d*MSG_W +: MSG_W];
            t  = m[2:0];
            oy = m[3 +: COORD_W];
            ox = m[3+COORD_W +: COORD_W];
            dy = (ypos >= oy) ? (ypos - oy) : (oy - ypos);
            diag_src = side_r ? (dd == 3'd1 || dd == 3'd3) : (dd == 3'd5 || dd == 3'd7);
            fl  = '0;
            hit = 1'b0;
            case (t)
                T_BISHOP, T_ROOK, T_QUEEN, T_KING: begin
                    hit   = cell_empty || cell_enemy;
                    fl[0] = cell_enemy;
                    if (cell_empty && (t == T_QUEEN || (t == T_BISHOP && dd[0]) ||
                                       (t == T_ROOK && !dd[0])))
                        step_out[((d+4)%8)*MSG_W +: MSG_W] = m;
                end
                T_PAWN: begin
                    if (dd == push_src && cell_empty) begin
                        hit   = 1'b1;
                        fl[4] = 1'b1;
                        fl[3] = (dy == COORD_W'(2));
                        // the forward port is always opposite the push source
                        if (oy == start_rank && dy == COORD_W'(1))
                            step_out[((d+4)%8)*MSG_W +: MSG_W] = m;
                    end else if (diag_src && (cell_enemy || ep_hit)) begin
                        hit   = 1'b1;
                        fl[0] = 1'b1;
                        fl[2] = ep_hit && cell_empty;
                    end
                    fl[5] = hit && (ypos == last_rank);
                end
                default: ;
            endcase
            step_pend[d] = hit;
            step_rec[d]  = {fl, ox, oy, xpos, ypos};

            km         = kn_in[d*MSG_W +: MSG_W];
            kn_pend[d] = (km[2:0] == T_KNIGHT) && (cell_empty || cell_enemy);
            kn_rec[d]  = {5'b0, cell_enemy, km[3+COORD_W +: COORD_W], km[3 +: COORD_W], xpos, ypos};
        end
    end

    logic                 own_start, b_en;
    logic [2:0]           bd;
    logic [MSG_W-1:0]     bmsg;
    logic [8*MSG_W-1:0]   bcast_out, kn_bcast;

    always_comb begin
        own_start = (cpiece[2:0] != T_EMPTY) && (cpiece[3] == side);
        bmsg      = {xpos, ypos, cpiece[2:0]};
        bcast_out = '0;
        kn_bcast  = '0;
        bd        = '0;
        b_en      = 1'b0;
        for (int d = 0; d < 8; d++) begin
            bd = 3'(d);
            case (cpiece[2:0])
                T_PAWN:          b_en = (bd == (side ? 3'd6 : 3'd2));
                T_BISHOP:        b_en = bd[0];
                T_ROOK:          b_en = !bd[0];
                T_QUEEN, T_KING: b_en = 1'b1;
                default:         b_en = 1'b0;
            endcase
            if (own_start && b_en)
                bcast_out[d*MSG_W +: MSG_W] = bmsg;
            if (own_start && cpiece[2:0] == T_KNIGHT)
                kn_bcast[d*MSG_W +: MSG_W] = bmsg;
        end
    end

    // Lowest pending direction drains first.
    always_comb begin
        low_bit = pend & (~pend + 8'd1);
        mv_data = '0;
        for (int d = 7; d >= 0; d--)
            if (pend[d]) mv_data = recs[d];
    end

    assign mv_valid = |pend;
    assign busy     = |pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            side_r  <= 1'b0;
            pend    <= '0;
            recs    <= '0;
            nbr_out <= '0;
            kn_out  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else if (start) begin
            state   <= S_PROP;
            side_r  <= side;
            pend    <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
            nbr_out <= bcast_out;
            kn_out  <= kn_bcast;
        end else begin
            if (mv_valid && mv_ready)
                pend <= pend & ~low_bit;
            case (state)
                S_PROP: begin
                    if (step) begin
                        if (kstep || pend != '0)
                            err <= 1'b1;
                        if (pend == '0) begin
                            pend    <= step_pend;
                            recs    <= step_rec;
                            nbr_out <= step_out;
                        end
                    end else if (kstep) begin
                        if (pend != '0) begin
                            err <= 1'b1;
                        end else begin
                            pend    <= kn_pend;
                            recs    <= kn_rec;
                            nbr_out <= '0;
                            state   <= S_KDRN;
                        end
                    end
                end
                S_KDRN: begin
                    if (step || kstep)
                        err <= 1'b1;
                    if (pend == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    if (step || kstep)
                        err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_cell_gen.sv
// tb/tb_square_cell_gen.sv - directed self-checking bench for square_cell_gen
module tb_square_cell_gen;

    localparam int C = 3;
    localparam int M = 2*C + 3;
    localparam int V = 6 + 4*C;

    logic           clk = 1'b0;
    logic           reset, side, ep_valid, start, step, kstep, mv_ready;
    logic [C-1:0]   xpos, ypos, ep_x, ep_y;
    logic [3:0]     cpiece;
    logic [8*M-1:0] nbr_in, nbr_out, kn_in, kn_out;
    logic           mv_valid, busy, done, err;
    logic [V-1:0]   mv_data;

    int n_vec = 0;
    int n_err = 0;

    square_cell_gen #(.COORD_W(C)) dut (
        .clk(clk), .reset(reset), .xpos(xpos), .ypos(ypos), .cpiece(cpiece),
        .side(side), .ep_valid(ep_valid), .ep_x(ep_x), .ep_y(ep_y),
        .start(start), .step(step), .kstep(kstep),
        .nbr_in(nbr_in), .nbr_out(nbr_out), .kn_in(kn_in), .kn_out(kn_out),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_data(mv_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8*M-1:0] obs, input logic [8*M-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [M-1:0] msg(input int x, input int y, input int t);
        return {C'(x), C'(y), 3'(t)};
    endfunction

    function automatic logic [V-1:0] rec(input logic [5:0] f, input int fx, input int fy,
                                         input int tx, input int ty);
        return {f, C'(fx), C'(fy), C'(tx), C'(ty)};
    endfunction

    function automatic logic [8*M-1:0] port(input int d, input logic [M-1:0] mm);
        logic [8*M-1:0] v;
        v = '0;
        v[d*M +: M] = mm;
        return v;
    endfunction

    task automatic do_start(input int x, input int y, input logic [3:0] pc, input logic sd);
        xpos = C'(x); ypos = C'(y); cpiece = pc; side = sd;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1; tick(); step = 1'b0; nbr_in = '0;
    endtask

    task automatic drain_one();
        mv_ready = 1'b1; tick(); mv_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; side = 0; ep_valid = 0; start = 0; step = 0; kstep = 0; mv_ready = 0;
        xpos = 0; ypos = 0; ep_x = 0; ep_y = 0; cpiece = 0; nbr_in = '0; kn_in = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_flags", {mv_valid, busy, done, err}, 4'b0000);
        chk("reset_nbr_out", nbr_out, '0);
        chk("reset_kn_out", kn_out, '0);
        chk("reset_mv_data", mv_data, '0);

        // step in IDLE is a protocol error
        do_step();
        chk("idle_step_err", err, 1'b1);

        // empty (3,3), rook arriving from the left
        do_start(3, 3, 4'h0, 1'b0);
        chk("start_clears_err", err, 1'b0);
        chk("empty_no_bcast", nbr_out, '0);
        nbr_in = port(0, msg(0, 3, 4));
        do_step();
        chk("rook_valid", mv_valid, 1'b1);
        chk("rook_rec", mv_data, rec(6'b000000, 0, 3, 3, 3));
        chk("rook_fwd", nbr_out, port(4, msg(0, 3, 4)));
        drain_one();
        chk("rook_drained", {mv_valid, busy}, 2'b00);

        // enemy black knight at (3,3), bishop capture
        do_start(3, 3, 4'hA, 1'b0);
        chk("enemy_kn_no_bcast", kn_out, '0);
        nbr_in = port(1, msg(1, 5, 3));
        do_step();
        chk("bishop_cap_rec", mv_data, rec(6'b000001, 1, 5, 3, 3));
        chk("bishop_cap_no_fwd", nbr_out, '0);
        drain_one();

        // own rook broadcast, own knight broadcast, then own-occupied blocks rays
        do_start(3, 3, 4'h4, 1'b0);
        chk("rook_bcast", nbr_out, port(0, msg(3, 3, 4)) | port(2, msg(3, 3, 4)) |
                                   port(4, msg(3, 3, 4)) | port(6, msg(3, 3, 4)));
        do_start(3, 3, 4'h2, 1'b0);
        chk("knight_bcast", kn_out, port(0, msg(3, 3, 2)) | port(1, msg(3, 3, 2)) |
                                    port(2, msg(3, 3, 2)) | port(3, msg(3, 3, 2)) |
                                    port(4, msg(3, 3, 2)) | port(5, msg(3, 3, 2)) |
                                    port(6, msg(3, 3, 2)) | port(7, msg(3, 3, 2)));
        chk("knight_no_ray_bcast", nbr_out, '0);
        nbr_in = port(0, msg(0, 3, 5));
        do_step();
        chk("own_blocks_move", mv_valid, 1'b0);
        chk("own_blocks_fwd", nbr_out, '0);
        chk("kn_out_holds", kn_out[3*M +: M], msg(3, 3, 2));

        // white pawn from (4,1): single push at (4,2), double step at (4,3)
        do_start(4, 2, 4'h0, 1'b0);
        nbr_in = port(6, msg(4, 1, 1));
        do_step();
        chk("push_rec", mv_data, rec(6'b010000, 4, 1, 4, 2));
        chk("push_fwd", nbr_out, port(2, msg(4, 1, 1)));
        drain_one();
        do_start(4, 3, 4'h0, 1'b0);
        nbr_in = port(6, msg(4, 1, 1));
        do_step();
        chk("dbl_rec", mv_data, rec(6'b011000, 4, 1, 4, 3));
        chk("dbl_no_fwd", nbr_out, '0);
        drain_one();

        // black pawn promotion at (2,0)
        do_start(2, 0, 4'h0, 1'b1);
        nbr_in = port(2, msg(2, 1, 1));
        do_step();
        chk("promo_rec", mv_data, rec(6'b110000, 2, 1, 2, 0));
        drain_one();

        // en passant onto (5,5), then a plain diagonal onto an empty square
        ep_valid = 1'b1; ep_x = 3'd5; ep_y = 3'd5;
        do_start(5, 5, 4'h0, 1'b0);
        nbr_in = port(7, msg(4, 4, 1));
        do_step();
        chk("ep_rec", mv_data, rec(6'b000101, 4, 4, 5, 5));
        drain_one();
        ep_valid = 1'b0;
        do_start(5, 5, 4'h0, 1'b0);
        nbr_in = port(7, msg(4, 4, 1));
        do_step();
        chk("diag_empty_no_move", mv_valid, 1'b0);

        // three rays, stalled consumer, ignored step mid-drain
        do_start(3, 3, 4'h0, 1'b0);
        nbr_in = port(0, msg(0, 3, 4)) | port(2, msg(3, 7, 4)) | port(6, msg(3, 0, 5));
        do_step();
        chk("multi_fwd", nbr_out, port(4, msg(0, 3, 4)) | port(6, msg(3, 7, 4)) |
                                  port(2, msg(3, 0, 5)));
        for (int i = 0; i < 4; i++) begin
            chk("stall_busy", busy, 1'b1);
            chk("stall_data", mv_data, rec(6'b000000, 0, 3, 3, 3));
            tick();
        end
        nbr_in = port(1, msg(1, 5, 3));
        do_step();
        chk("busy_step_err", err, 1'b1);
        chk("busy_step_data", mv_data, rec(6'b000000, 0, 3, 3, 3));
        chk("busy_step_fwd", nbr_out, port(4, msg(0, 3, 4)) | port(6, msg(3, 7, 4)) |
                                      port(2, msg(3, 0, 5)));
        mv_ready = 1'b1;
        tick();
        chk("drain_d2", mv_data, rec(6'b000000, 3, 7, 3, 3));
        tick();
        chk("drain_d6", mv_data, rec(6'b000000, 3, 0, 3, 3));
        tick();
        chk("drain_empty", {mv_valid, busy}, 2'b00);
        mv_ready = 1'b0;

        // knight round then completion
        do_start(3, 3, 4'h0, 1'b0);
        kn_in = port(3, msg(5, 4, 2));
        kstep = 1'b1; tick(); kstep = 1'b0; kn_in = '0;
        chk("knight_rec", mv_data, rec(6'b000000, 5, 4, 3, 3));
        chk("knight_nbr_empty", nbr_out, '0);
        chk("knight_not_done", done, 1'b0);
        mv_ready = 1'b1;
        for (int i = 0; i < 10 && !done; i++) tick();
        mv_ready = 1'b0;
        chk("done_set", {done, mv_valid}, 2'b10);

        // step and kstep together: step wins, err set
        do_start(3, 3, 4'h0, 1'b0);
        chk("restart_clears_done", done, 1'b0);
        nbr_in = port(0, msg(0, 3, 4));
        kstep = 1'b1;
        do_step();
        kstep = 1'b0;
        chk("both_err", err, 1'b1);
        chk("both_step_rec", mv_data, rec(6'b000000, 0, 3, 3, 3));

        // reset in the middle of a drain
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_drain_flags", {mv_valid, busy, done, err}, 4'b0000);
        chk("rst_drain_out", nbr_out | kn_out, '0);
        mv_ready = 1'b1; tick();
        chk("rst_drain_quiet", mv_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
